// File: rtl/bus_target_pkg.sv
// Shared types and default constants for the bus_target_v1 register target.
package bus_target_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    READY  = 3'd2,
    DONE   = 3'd3,
    IGNORE = 3'd4
  } state_t;

  localparam int ERRCNT_W        = 8;
  localparam int WAITCNT_W       = 4;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_NREGS       = 8;
  localparam int DEF_BASE_ADDR   = 'h40;
  localparam int DEF_WAIT_STATES = 2;

endpackage

// File: rtl/bus_target_regfile.sv
// Register bank for bus_target_v1: one write port, one read port whose output
// is captured when the target latches the register index.
module bus_target_regfile
  import bus_target_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  localparam int IDX_W = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              writeEn,
  input  logic [IDX_W-1:0]  writeIndex,
  input  logic [DATA_W-1:0] writeData,
  input  logic              readEn,
  input  logic [IDX_W-1:0]  readIndex,
  output logic [DATA_W-1:0] readData
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      readData <= '0;
    end else begin
      if (writeEn) begin
        regs[writeIndex] <= writeData;
      end
      if (readEn) begin
        readData <= regs[readIndex];
      end
    end
  end

endmodule

// File: rtl/bus_target_v1.sv
// Wait-state register target on an arbitrated bus. Define BUS_TARGET_ERRCNT_EN
// to build the saturating aborted-cycle counter; otherwise err_cnt reads zero.
module bus_target_v1
  import bus_target_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                NREGS       = DEF_NREGS,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
  parameter int                WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                clock,
  input  logic                nreset,
  input  logic                addressvalid,
  input  logic [ADDR_W-1:0]   address,
  input  logic                wr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                DataStrobe,
  input  logic                Error,
  output logic                TargetReady,
  output logic [DATA_W-1:0]   rdata,
  output logic                rdata_oe,
  output logic                hit,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int IDX_W = $clog2(NREGS);

  state_t                state;
  logic [WAITCNT_W-1:0]  waitCnt;
  logic                  armed;
  logic                  addrHit;
  logic [IDX_W-1:0]      regIndex;
  logic                  regWrite;
  logic                  regRead;
  logic [DATA_W-1:0]     rdataQ;

  assign addrHit  = (address[ADDR_W-1:IDX_W] == BASE_ADDR[ADDR_W-1:IDX_W]);
  assign regIndex = address[IDX_W-1:0];
  assign regRead  = (state == IDLE) && addressvalid;
  assign regWrite = (state == READY) && DataStrobe && wr;

  bus_target_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) regfile (
    .clock      (clock),
    .nreset     (nreset),
    .writeEn    (regWrite),
    .writeIndex (regIndex),
    .writeData  (wdata),
    .readEn     (regRead),
    .readIndex  (regIndex),
    .readData   (rdataQ)
  );

  // armed only goes high once addressvalid has been seen low, so a request
  // still held across reset or an abort can never start a second cycle.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state       <= IDLE;
      waitCnt     <= '0;
      armed       <= 1'b0;
      TargetReady <= 1'b0;
      rdata_oe    <= 1'b0;
      rdata       <= '0;
      hit         <= 1'b0;
    end else begin
      if (!addressvalid) begin
        armed <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (addressvalid) begin
            armed <= 1'b0;
            if (armed && addrHit) begin
              state   <= WAIT;
              waitCnt <= WAITCNT_W'(WAIT_STATES);
              hit     <= 1'b1;
            end else begin
              state <= IGNORE;
            end
          end
        end
        WAIT: begin
          if (!addressvalid || Error) begin
            state   <= IDLE;
            waitCnt <= '0;
            hit     <= 1'b0;
          end else if (waitCnt == '0) begin
            state       <= READY;
            TargetReady <= 1'b1;
            rdata_oe    <= ~wr;
            rdata       <= wr ? '0 : rdataQ;
          end else begin
            waitCnt <= waitCnt - WAITCNT_W'(1);
          end
        end
        READY: begin
          // A strobe completes the cycle even if Error arrives with it.
          if (DataStrobe) begin
            state       <= DONE;
            TargetReady <= 1'b0;
            rdata_oe    <= 1'b0;
            rdata       <= '0;
          end else if (!addressvalid || Error) begin
            state       <= IDLE;
            TargetReady <= 1'b0;
            rdata_oe    <= 1'b0;
            rdata       <= '0;
            hit         <= 1'b0;
          end
        end
        DONE, IGNORE: begin
          if (!addressvalid) begin
            state <= IDLE;
            hit   <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          TargetReady <= 1'b0;
          rdata_oe    <= 1'b0;
          rdata       <= '0;
          hit         <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUS_TARGET_ERRCNT_EN
  logic [ERRCNT_W-1:0] errCount;
  logic                countErr;

  assign countErr = Error && ((state == WAIT) || ((state == READY) && !DataStrobe));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      errCount <= '0;
    end else if (countErr && (errCount != '1)) begin
      errCount <= errCount + ERRCNT_W'(1);
    end
  end

  assign err_cnt = errCount;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_target_v1.sv
// Randomized scoreboard bench for bus_target_v1 with a behavioural register model.
module tb_bus_target_v1;

  localparam int WS = 2;
  localparam int M_NORMAL   = 0;
  localparam int M_ERRWAIT  = 1;
  localparam int M_DROP     = 2;
  localparam int M_ERRREADY = 3;
  localparam int M_BOTH     = 4;
  localparam int M_RESET    = 5;

  logic        clock = 1'b0;
  logic        nreset = 1'b1;
  logic        addressvalid = 1'b0;
  logic [7:0]  address = '0;
  logic        wr = 1'b0;
  logic [15:0] wdata = '0;
  logic        DataStrobe = 1'b0;
  logic        Error = 1'b0;
  logic        TargetReady;
  logic [15:0] rdata;
  logic        rdata_oe;
  logic        hit;
  logic [7:0]  err_cnt;

  typedef struct {
    logic        oe;
    logic [15:0] data;
    logic [7:0]  addr;
  } exp_t;

  exp_t        sbQ[$];
  logic [15:0] model [8];
  int          errModel = 0;
  int          checks = 0;
  int          errors = 0;
  int          txnNum = 0;
  logic        trPrev = 1'b0;

  bus_target_v1 dut (
    .clock        (clock),
    .nreset       (nreset),
    .addressvalid (addressvalid),
    .address      (address),
    .wr           (wr),
    .wdata        (wdata),
    .DataStrobe   (DataStrobe),
    .Error        (Error),
    .TargetReady  (TargetReady),
    .rdata        (rdata),
    .rdata_oe     (rdata_oe),
    .hit          (hit),
    .err_cnt      (err_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic checkErr(input string name);
    int e;
`ifdef BUS_TARGET_ERRCNT_EN
    e = errModel;
`else
    e = 0;
`endif
    check(err_cnt == 8'(e), name, err_cnt, e);
  endtask

  function automatic void bumpErr();
    if (errModel < 255) errModel++;
  endfunction

  // Monitor: every rising TargetReady must match the oldest expected response.
  always @(negedge clock) begin
    if (TargetReady && !trPrev) begin
      if (sbQ.size() == 0) begin
        check(1'b0, "unexpected_ready", {rdata_oe, rdata}, 0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        check((rdata_oe === e.oe) && (rdata === e.data) && (hit === 1'b1),
              "ready_response", {hit, 3'b0, rdata_oe, rdata}, {1'b1, 3'b0, e.oe, e.data});
      end
    end
    trPrev = TargetReady;
  end

  // Called just after a negedge; returns just after a negedge with addressvalid low.
  task automatic runTxn(input logic [7:0] a, input logic w, input logic [15:0] d, input int mode);
    bit   isHit;
    int   idx;
    int   n;
    bit   seen;
    exp_t e;
    isHit = (a[7:3] == 5'h08);
    idx   = int'(a[2:0]);
    txnNum++;
    addressvalid = 1'b1;
    address      = a;
    wr           = w;
    wdata        = d;
    if (isHit && mode != M_ERRWAIT) begin
      e.oe   = ~w;
      e.data = w ? 16'h0 : model[idx];
      e.addr = a;
      sbQ.push_back(e);
    end
    if (!isHit) begin
      for (int k = 0; k < WS + 4; k++) begin
        @(negedge clock);
        check(!TargetReady && !hit && !rdata_oe && rdata == 0, "ignore_quiet",
              {TargetReady, hit, rdata_oe, rdata}, 0);
      end
      addressvalid = 1'b0;
      @(negedge clock);
      $display("txn %0d addr %h wr %0d miss", txnNum, a, w);
      return;
    end
    @(negedge clock);
    check(hit && !TargetReady, "wait_hit", {hit, TargetReady}, 2'b10);
    if (mode == M_ERRWAIT) begin
      Error = 1'b1;
      @(negedge clock);
      Error = 1'b0;
      bumpErr();
      check(!TargetReady && !hit, "err_wait_abort", {TargetReady, hit}, 0);
      addressvalid = 1'b0;
      @(negedge clock);
      checkErr("err_cnt_wait");
      $display("txn %0d addr %h wr %0d error-in-wait err_cnt %0d", txnNum, a, w, err_cnt);
      return;
    end
    n    = 0;
    seen = TargetReady;
    while (!seen && n < 20) begin
      @(negedge clock);
      n++;
      seen = TargetReady;
    end
    if (!seen) begin
      check(1'b0, "ready_timeout", n, WS + 1);
      void'(sbQ.pop_front());
      addressvalid = 1'b0;
      @(negedge clock);
      return;
    end
    check(n == WS + 1, "ready_latency", n, WS + 1);
    case (mode)
      M_DROP: begin
        addressvalid = 1'b0;
        @(negedge clock);
        check(!TargetReady && !hit && !rdata_oe, "drop_abort", {TargetReady, hit, rdata_oe}, 0);
      end
      M_ERRREADY: begin
        Error = 1'b1;
        @(negedge clock);
        Error = 1'b0;
        bumpErr();
        check(!TargetReady && !hit && !rdata_oe, "err_ready_abort", {TargetReady, hit, rdata_oe}, 0);
        addressvalid = 1'b0;
        @(negedge clock);
      end
      M_BOTH: begin
        DataStrobe = 1'b1;
        Error      = 1'b1;
        @(negedge clock);
        DataStrobe = 1'b0;
        Error      = 1'b0;
        if (w) model[idx] = d;
        check(!TargetReady && hit && !rdata_oe && rdata == 0, "strobe_wins",
              {TargetReady, hit, rdata_oe, rdata}, {1'b0, 1'b1, 1'b0, 16'h0});
        addressvalid = 1'b0;
        @(negedge clock);
      end
      M_RESET: begin
        #2 nreset = 1'b0;
        #1;
        check(!TargetReady && !hit && !rdata_oe && rdata == 0 && err_cnt == 0, "reset_in_ready",
              {TargetReady, hit, rdata_oe, rdata, err_cnt}, 0);
        foreach (model[i]) model[i] = 16'h0;
        errModel = 0;
        @(negedge clock);
        #2 nreset = 1'b1;
        for (int k = 0; k < WS + 4; k++) begin
          @(negedge clock);
          check(!TargetReady && !hit, "hold_after_reset", {TargetReady, hit}, 0);
        end
        addressvalid = 1'b0;
        @(negedge clock);
      end
      default: begin
        DataStrobe = 1'b1;
        @(negedge clock);
        DataStrobe = 1'b0;
        if (w) model[idx] = d;
        check(!TargetReady && hit && !rdata_oe && rdata == 0, "done_outputs",
              {TargetReady, hit, rdata_oe, rdata}, {1'b0, 1'b1, 1'b0, 16'h0});
        addressvalid = 1'b0;
        @(negedge clock);
        check(!hit && !TargetReady, "back_to_idle", {hit, TargetReady}, 0);
      end
    endcase
    checkErr("err_cnt_txn");
    $display("txn %0d addr %h wr %0d wdata %h mode %0d err_cnt %0d", txnNum, a, w, d, mode, err_cnt);
  endtask

  initial begin
    logic [7:0]  a;
    logic [15:0] d;
    int          r;
    int          mode;
    foreach (model[i]) model[i] = 16'h0;
    #1 nreset = 1'b0;
    #2;
    check(!TargetReady && !hit && !rdata_oe && rdata == 0 && err_cnt == 0, "reset_state",
          {TargetReady, hit, rdata_oe, rdata, err_cnt}, 0);
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    repeat (2) @(negedge clock);

    runTxn(8'h40, 1'b1, 16'hA5A5, M_NORMAL);
    runTxn(8'h40, 1'b0, 16'h0000, M_NORMAL);
    runTxn(8'h48, 1'b0, 16'h0000, M_NORMAL);
    runTxn(8'h43, 1'b1, 16'hBEEF, M_ERRWAIT);
    runTxn(8'h43, 1'b0, 16'h0000, M_NORMAL);
    runTxn(8'h44, 1'b1, 16'h1234, M_DROP);
    runTxn(8'h44, 1'b0, 16'h0000, M_NORMAL);
    runTxn(8'h45, 1'b1, 16'h5A5A, M_BOTH);
    runTxn(8'h45, 1'b0, 16'h0000, M_NORMAL);

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = 8'($urandom_range(0, 255));
        while (a[7:3] == 5'h08) a = 8'($urandom_range(0, 255));
      end else begin
        a = 8'h40 | 8'($urandom_range(0, 7));
      end
      d = 16'($urandom);
      r = $urandom_range(0, 9);
      mode = (r == 5) ? M_ERRWAIT : (r == 6) ? M_DROP : (r == 7) ? M_ERRREADY :
             (r == 8) ? M_BOTH : M_NORMAL;
      runTxn(a, 1'($urandom_range(0, 1)), d, mode);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    for (int t = 0; t < 260; t++) begin
      runTxn(8'h40 | 8'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom), M_ERRWAIT);
    end
    checkErr("err_cnt_saturated");

    runTxn(8'h42, 1'b0, 16'h0000, M_RESET);
    for (int i = 0; i < 8; i++) begin
      runTxn(8'h40 | 8'(i), 1'b0, 16'h0000, M_NORMAL);
    end
    runTxn(8'h47, 1'b1, 16'hC3C3, M_NORMAL);
    runTxn(8'h47, 1'b0, 16'h0000, M_NORMAL);

    repeat (3) @(negedge clock);
    check(sbQ.size() == 0, "scoreboard_drained", sbQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bus_target_v1.md
BUS_TARGET_V1 -- requirements
Module: bus_target_v1

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, address width; DATA_W, default 16, data width; NREGS, default 8 (power of 2, at least 2), register count; BASE_ADDR, default 8'h40, decode base; WAIT_STATES, default 2 (range 0..8), clocks inserted before TargetReady.
REQ-002 clock  in  1  system clock, all state on posedge.
REQ-003 nreset  in  1  asynchronous active-low reset.
REQ-004 addressvalid  in  1  arbiter address-valid; address, wr and wdata are stable while it is high.
REQ-005 address  in  ADDR_W  granted master's address.
REQ-006 wr  in  1  1 = write, 0 = read.
REQ-007 wdata  in  DATA_W  write data.
REQ-008 DataStrobe  in  1  one-clock arbiter strobe.
REQ-009 Error  in  1  one-clock arbiter timeout pulse.
REQ-010 TargetReady  out  1  registered ready to arbiter.
REQ-011 rdata  out  DATA_W  read data, zero when rdata_oe is low.
REQ-012 rdata_oe  out  1  read-data drive enable for the shared bus mux.
REQ-013 hit  out  1  this target is selected for the current cycle.
REQ-014 err_cnt  out  8  saturating count of aborted selected cycles.

Function
REQ-015 Hit SHALL be address[ADDR_W-1:log2(NREGS)] == BASE_ADDR[ADDR_W-1:log2(NREGS)]; register index = address[log2(NREGS)-1:0].
REQ-016 FSM states SHALL be IDLE, WAIT, READY, DONE, IGNORE.
REQ-017 IDLE: at a clock with addressvalid=1, go to WAIT with wait counter = WAIT_STATES on hit, else go to IGNORE; in the same clock latch rdata_q = regs[index].
REQ-018 WAIT: decrement the counter; at counter = 0 go to READY and register TargetReady=1, so TargetReady rises exactly WAIT_STATES+1 clocks after the IDLE sampling edge.
REQ-019 READY: TargetReady=1; rdata_oe = ~wr; rdata = rdata_q; DataStrobe=1 -> on write, regs[index] <= wdata at that edge; go to DONE.
REQ-020 DONE and IGNORE: TargetReady=0, rdata_oe=0; go to IDLE only at a clock with addressvalid=0 (no re-trigger on a held addressvalid).
REQ-021 In WAIT or READY, addressvalid=0 or Error=1 SHALL abort to IDLE with no register write; Error=1 SHALL also increment err_cnt, saturating at 255.
REQ-022 If DataStrobe and Error are high together in READY, DataStrobe SHALL win (write committed, no count).
REQ-023 hit SHALL be high in WAIT, READY and DONE, and low otherwise.
REQ-024 At most one register write SHALL occur per addressvalid assertion.

Reset
REQ-025 nreset low SHALL force IDLE asynchronously, with TargetReady=0, rdata_oe=0, rdata=0, hit=0, err_cnt=0, all regs=0 and counter=0.
REQ-026 Reset mid-cycle SHALL drop TargetReady immediately; after release the FSM waits in IGNORE until it sees addressvalid=0 if addressvalid is still high.

Configuration
REQ-027 Macro BUS_TARGET_ERRCNT_EN defined: err_cnt behaves per REQ-021. Undefined: err_cnt is tied to 0, no counter logic, and Error still aborts.

Structure
REQ-028 Package bus_target_pkg SHALL hold the state enum, the ERRCNT_W=8 constant and the default parameter constants.
REQ-029 Register storage SHALL be sub-module bus_target_regfile (one write port, one read port registered at index latch).

Verification
REQ-030 Reset, then write 0x40 wr=1 wdata=16'hA5A5, WAIT_STATES=2 -> TargetReady high at IDLE edge +3; on DataStrobe, reg0=A5A5; next clock TargetReady=0.
REQ-031 Read 0x40 after REQ-030 -> rdata_oe=1 and rdata=16'hA5A5 in READY; rdata=0 after DataStrobe.
REQ-032 Address 0x48 -> IGNORE; TargetReady, hit and rdata_oe stay 0 throughout; IDLE after addressvalid falls.
REQ-033 Write 0x43 with Error pulsed in WAIT -> reg3 unchanged; err_cnt=1 with the macro defined, 0 without; IDLE.
REQ-034 addressvalid dropped in READY with no DataStrobe -> IDLE and no write; 256 Error aborts -> err_cnt=255.
REQ-035 nreset asserted in READY -> TargetReady=0 with no clock edge; addressvalid still high after release -> no TargetReady until addressvalid toggles.
